// File: rtl/display_pkg.sv
//------------------------------------------------------------------------------
// display_pkg
// Shared state encoding and seven-segment codes (active-low, {g,f,e,d,c,b,a}).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
//------------------------------------------------------------------------------
// seg7_decoder
// BCD digit plus blank flag to active-low seven-segment pattern.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/hex_value_display.sv
//------------------------------------------------------------------------------
// hex_value_display
// Shows a signed n-bit value as sign + three decimal digits via double-dabble.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hex_value_display
    import display_pkg::*;
#(
    parameter int N          = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] value,
    output logic         busy,
    output logic [6:0]   hex0,
    output logic [6:0]   hex1,
    output logic [6:0]   hex2,
    output logic [6:0]   hex3
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(N - 1);

    state_t             state_q;
    logic               sign_q;
    logic [N-1:0]       mag_q;
    logic [N-1:0]       cap_q;
    logic [N-1:0]       shown_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [N-1:0]       mag_d;
    logic [N-1:0]       mag_shift_d;
    logic [BCD_W-1:0]   bcd_adj_d;
    logic [BCD_W-1:0]   bcd_d;
    logic [6:0]         seg_units_d;
    logic [6:0]         seg_tens_d;
    logic [6:0]         seg_hund_d;
    logic               blank_hund_d;
    logic               blank_tens_d;

    // Two's-complement negate on N bits, so the most negative value maps to 2^(N-1).
    assign mag_d = value[N-1] ? (~value + {{(N-1){1'b0}}, 1'b1}) : value;

    generate
        for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
            assign bcd_adj_d[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ?
                                         (bcd_q[4*i +: 4] + 4'd3) : bcd_q[4*i +: 4];
        end
    endgenerate

    assign {bcd_d, mag_shift_d} = {bcd_adj_d, mag_q} << 1;

    assign blank_hund_d = (bcd_q[11:8] == 4'd0);
    assign blank_tens_d = blank_hund_d && (bcd_q[7:4] == 4'd0);

    seg7_decoder u_dec_units (.bcd_i(bcd_q[3:0]),  .blank_i(1'b0),         .seg_o(seg_units_d));
    seg7_decoder u_dec_tens  (.bcd_i(bcd_q[7:4]),  .blank_i(blank_tens_d), .seg_o(seg_tens_d));
    seg7_decoder u_dec_hund  (.bcd_i(bcd_q[11:8]), .blank_i(blank_hund_d), .seg_o(seg_hund_d));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            cap_q   <= '0;
            shown_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hex0    <= SEG_0;
            hex1    <= SEG_BLANK;
            hex2    <= SEG_BLANK;
            hex3    <= SEG_BLANK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (value != shown_q) begin
                        state_q <= CONV;
                        busy    <= 1'b1;
                        sign_q  <= value[N-1];
                        mag_q   <= mag_d;
                        cap_q   <= value;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_d;
                    mag_q <= mag_shift_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST_STEP) begin
                        state_q <= UPDATE;
                    end
                end
                UPDATE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    shown_q <= cap_q;
                    hex0    <= seg_units_d;
                    hex1    <= seg_tens_d;
                    hex2    <= seg_hund_d;
                    hex3    <= sign_q ? SEG_MINUS : SEG_BLANK;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/hex_value_display.md
Name: hex_value_display

Overview:
- Downstream consumer of the CPU's n-bit signed output value (the word driven to LED).
- Renders that value as signed decimal on four active-low seven-segment digits: hex3 = sign, hex2..hex0 = hundreds/tens/units.
- Uses a sequential shift-add-3 (double-dabble) converter. The converter restarts automatically whenever the input differs from the value currently displayed.
- Gives the board a human-readable view of accumulator and register results without software changes.

Parameters:
- n, 8, width of the signed input value; the design supports n = 8 only, since three BCD digits cover -128..127.
- BCD_DIGITS, 3, number of magnitude digits; fixed at 3 for n = 8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  n  signed two's-complement value to display, sampled from the CPU output.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- hex0  output  7  units digit, active-low, bit order {g,f,e,d,c,b,a}.
- hex1  output  7  tens digit, active-low.
- hex2  output  7  hundreds digit, active-low.
- hex3  output  7  sign digit, active-low.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE, busy = 0, shown_value = 0.
  - hex0 = 7'h40 ('0'); hex1, hex2, hex3 = 7'h7F (blank).
  - Reset mid-conversion aborts the conversion; nothing partial reaches the hex outputs.
- States: IDLE, CONV, UPDATE. Transitions:
  - IDLE -> CONV when value != shown_value. On that edge, capture the value:
    - sign = value[n-1];
    - mag = |value| as an n-bit unsigned number, so -128 gives 8'd128;
    - clear the BCD register (4*BCD_DIGITS bits) and the counter.
  - IDLE -> IDLE otherwise; all outputs hold.
  - CONV: one double-dabble step per cycle.
    - Each BCD nibble >= 5 gets +3, then {bcd, mag} shifts left by 1.
    - Counter increments each step; after exactly n steps, go to UPDATE.
  - UPDATE -> IDLE:
    - register all four hex outputs from the final BCD digits;
    - shown_value <= captured value.
- Latency: value changes before edge 1.
  - Edge 1: capture.
  - Edges 2..n+1: n shifts.
  - Edge n+2: outputs update.
  - Total n+2 = 10 cycles. busy is high after edge 1 and low after edge n+2.
- Value changing during CONV/UPDATE is ignored; the captured value completes first. The IDLE compare on the following edge then starts a new conversion, so busy drops for exactly one cycle.
- Blanking and sign:
  - hex2 is blank when hundreds = 0.
  - hex1 is blank when hundreds = 0 and tens = 0.
  - hex0 is always shown.
  - hex3 = 7'h3F (minus, g only) when sign = 1, else blank 7'h7F.
- Digit codes:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - BCD > 9 cannot occur; the decoder maps it to blank.
- All hex outputs are registered; no combinational path from value to hex*.

Decomposition:
- Shared package display_pkg:
  - state enum (IDLE, CONV, UPDATE);
  - SEG_BLANK = 7'h7F, SEG_MINUS = 7'h3F;
  - the ten digit code constants.
- One sub-module, seg7_decoder: combinational 4-bit BCD plus blank flag -> 7-bit active-low segments. Instantiated three times for the magnitude digits.
- The FSM, magnitude logic and double-dabble datapath stay in hex_value_display.

Test Plan:
- Reset check: assert reset, value = 0 -> hex0 = 7'h40, hex1/hex2/hex3 = 7'h7F, busy = 0. Hold value = 0 for 20 cycles -> busy never rises.
- Positive value: value = 45 -> busy = 1 after edge 1. After edge 10: hex0 = 7'h12, hex1 = 7'h19, hex2 = 7'h7F, hex3 = 7'h7F, busy = 0.
- Negative value: value = -12 -> after 10 edges: hex3 = 7'h3F, hex2 = 7'h7F, hex1 = 7'h79, hex0 = 7'h24.
- Boundary value: value = -128 -> hex3 = 7'h3F, hex2 = 7'h79, hex1 = 7'h24, hex0 = 7'h00. Then value = 127 -> hex3 blank, hex2 = 7'h79, hex1 = 7'h24, hex0 = 7'h78.
- Change mid-conversion: value = 6, switch to -1 after edge 3.
  - After edge 10: hex0 = 7'h02, hex3 blank.
  - busy low for one cycle, then high again.
  - After edge 21: hex0 = 7'h79, hex3 = 7'h3F.
- Reset mid-conversion: value = 45, assert reset after edge 5 -> outputs return to reset values immediately. Release reset -> conversion of 45 restarts and completes 10 cycles later.
